// File: rtl/uart_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared UART definitions: FSM state encoding, parity mode constants and the
// default baud divisor. A future receiver imports the same package.
// No ports.
// -----------------------------------------------------------------------------
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; bitDone pulses for
// one cycle in the last cycle of each bit period. restart holds the count at
// zero, so the first period after restart drops is a full CLKS_PER_BIT cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   restart  in   synchronous clear / hold at zero
//   bitDone  out  high in the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bitDone
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bitDone = !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises DATA_BITS-wide words onto a UART line, LSB first:
// start(0), data, optional parity, STOP_BITS stop bits(1). tx comes straight
// from a flop and only changes at bit boundaries.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   dataIn     in   word to send, latched on the valid/ready handshake
//   dataValid  in   producer offers dataIn
//   dataReady  out  transmitter idle and able to accept a word
//   tx         out  serial line, idles high
//   busy       out  frame in progress (inverse of dataReady)
//
// Handshake: a word transfers on a rising edge where dataValid && dataReady.
// dataValid without dataReady is ignored; dataValid may be held across frames.
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 dataValid,
    output logic                 dataReady,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
    // Odd parity is even parity seeded with 1.
    localparam logic PAR_SEED  = (PARITY == PARITY_ODD);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_e               state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q,  parity_d;
    logic                 tx_q,      tx_d;
    logic                 bit_done;
    logic                 baud_restart;

    // The timer is parked at zero while idle so START gets a full bit period.
    assign baud_restart = (state_q == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(baud_restart),
        .bitDone(bit_done)
    );

    // tx_d is the level for the next bit, loaded on the edge that ends the
    // current one, so tx itself is a plain register.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (dataValid) begin
                    shift_d    = dataIn;
                    parity_d   = PAR_SEED;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_done) begin
                    // Parity accumulates from the latched word as it shifts out.
                    shift_d  = shift_q >> 1;
                    parity_d = parity_q ^ shift_q[0];
                    if (bit_idx_q == LAST_IDX) begin
                        if (HAS_PARITY) begin
                            tx_d    = parity_q ^ shift_q[0];
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_done) begin
                    tx_d = 1'b1;
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign dataReady = (state_q == ST_IDLE);
    assign busy      = !dataReady;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Four transmitter instances with CLKS_PER_BIT=4:
//   0: 8N1   1: 8E1   2: 8O1   3: 7N2
// A frame-level model turns each accepted word into a queue of expected tx
// levels, one per clock, and a compare process checks tx/dataReady/busy of the
// selected instance on every falling edge. Hand-written frame patterns and
// lengths pin the model.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CLKS = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [8:0] din = '0;
    logic [3:0] dv  = '0;
    logic [3:0] tx_all, rdy_all, busy_all;
    int sel = 0;

    int cfg_db[4]   = '{8, 8, 8, 7};
    int cfg_par[4]  = '{0, 1, 2, 0};
    int cfg_stop[4] = '{1, 1, 1, 2};

    uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .dataIn(din[7:0]), .dataValid(dv[0]),
        .dataReady(rdy_all[0]), .tx(tx_all[0]), .busy(busy_all[0]));
    uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .dataIn(din[7:0]), .dataValid(dv[1]),
        .dataReady(rdy_all[1]), .tx(tx_all[1]), .busy(busy_all[1]));
    uart_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .dataIn(din[7:0]), .dataValid(dv[2]),
        .dataReady(rdy_all[2]), .tx(tx_all[2]), .busy(busy_all[2]));
    uart_transmitter #(.DATA_BITS(7), .CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .dataIn(din[6:0]), .dataValid(dv[3]),
        .dataReady(rdy_all[3]), .tx(tx_all[3]), .busy(busy_all[3]));

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    logic [0:0] exp_q[$];
    logic exp_tx   = 1'b1;
    logic in_frame = 1'b0;

    task automatic push_frame(input logic [8:0] d);
        int ones;
        logic p;
        ones = 0;
        repeat (CLKS) exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_db[sel]; i++) begin
            ones += int'(d[i]);
            repeat (CLKS) exp_q.push_back(d[i]);
        end
        if (cfg_par[sel] != 0) begin
            p = ((ones % 2) == 1) ^ (cfg_par[sel] == 2);
            repeat (CLKS) exp_q.push_back(p);
        end
        repeat (cfg_stop[sel] * CLKS) exp_q.push_back(1'b1);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            in_frame = 1'b0;
            exp_tx   = 1'b1;
        end else begin
            if (!in_frame && dv[sel]) push_frame(din);
            if (exp_q.size() > 0) begin
                exp_tx   = exp_q.pop_front();
                in_frame = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                in_frame = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model tx", tx_all[sel], exp_tx);
            cmp("model dataReady", rdy_all[sel], !in_frame);
            cmp("model busy", busy_all[sel], in_frame);
        end
    end

    // ---------------- driver tasks ----------------
    // Offers d to instance s and returns just after the handshake edge.
    task automatic send(input int s, input logic [8:0] d, input bit hold);
        bit was_rdy;
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        din   = d;
        dv[s] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            was_rdy = rdy_all[s];
            @(posedge clk);
            if (was_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmp("handshake", ok, 1'b1);
        if (!hold) begin
            #1;
            dv[s] = 1'b0;
        end
    endtask

    // Called just after a handshake edge: checks bit i mid-period and the
    // number of cycles dataReady stays low.
    task automatic frame_check(input int s, input string name, input logic [15:0] bits,
                               input int nbits, input int exp_len);
        int  low;
        bit  done;
        low  = 0;
        done = 1'b0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            if (rdy_all[s] == 1'b0) low++;
            else done = 1'b1;
            for (int i = 0; i < nbits; i++) begin
                if (k == CLKS * i + 2) cmp($sformatf("%s bit%0d", name, i), tx_all[s], bits[i]);
            end
        end
        cmp_int({name, " ready-low cycles"}, low, exp_len);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] b2b_bits;
    int          b2b_low;
    bit          b2b_done;

    initial begin
        // Reset held with dataValid asserted: nothing may start.
        reset = 1'b0;
        dv    = 4'b0001;
        din   = 9'h055;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            cmp("reset tx", tx_all[0], 1'b1);
            cmp("reset dataReady", rdy_all[0], 1'b1);
            cmp("reset busy", busy_all[0], 1'b0);
        end
        dv    = '0;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        cmp("post-reset idle tx", tx_all[0], 1'b1);

        // Basic 8N1 frame {stop, data, start}
        sel = 0;
        send(0, 9'h055, 1'b0);
        frame_check(0, "8N1 0x55", 16'b1_01010101_0, 10, 40);

        // Back-to-back with dataValid held and dataIn changed mid-frame.
        b2b_bits = 16'b1_10100011_0;
        send(0, 9'h0A3, 1'b1);
        b2b_low  = 0;
        b2b_done = 1'b0;
        for (int k = 1; k <= 200 && !b2b_done; k++) begin
            @(negedge clk);
            if (k == 10) din = 9'h03C;
            if (rdy_all[0] == 1'b0) b2b_low++;
            else b2b_done = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (k == CLKS * i + 2) cmp($sformatf("b2b 0xA3 bit%0d", i), tx_all[0], b2b_bits[i]);
            end
        end
        cmp_int("b2b first ready-low cycles", b2b_low, 40);
        cmp("b2b gap tx", tx_all[0], 1'b1);
        @(negedge clk);
        cmp("b2b second start tx", tx_all[0], 1'b0);
        cmp("b2b second dataReady", rdy_all[0], 1'b0);
        dv[0] = 1'b0;
        frame_check(0, "b2b 0x3C", 16'h0000, 0, 39);

        // Even parity
        sel = 1;
        send(1, 9'h007, 1'b0);
        frame_check(1, "8E1 0x07", 16'b1_1_00000111_0, 11, 44);
        send(1, 9'h003, 1'b0);
        frame_check(1, "8E1 0x03", 16'b1_0_00000011_0, 11, 44);

        // Odd parity
        sel = 2;
        send(2, 9'h007, 1'b0);
        frame_check(2, "8O1 0x07", 16'b1_0_00000111_0, 11, 44);
        send(2, 9'h003, 1'b0);
        frame_check(2, "8O1 0x03", 16'b1_1_00000011_0, 11, 44);

        // Reset during the third data bit, between clock edges.
        sel = 0;
        send(0, 9'h0A5, 1'b0);
        repeat (14) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmp("async reset tx", tx_all[0], 1'b1);
        cmp("async reset dataReady", rdy_all[0], 1'b1);
        cmp("async reset busy", busy_all[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 9'h0F0, 1'b0);
        frame_check(0, "after reset 0xF0", 16'b1_11110000_0, 10, 40);

        // 7 data bits, 2 stop bits
        sel = 3;
        send(3, 9'h07F, 1'b0);
        frame_check(3, "7N2 0x7F", 16'b11_1111111_0, 10, 40);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
